keycode_filter: RTL and testbench

KEYCODE_FILTER -- requirements
Module: keycode_filter

---
 rtl/keycode_filter_if.sv | 31 +++
 rtl/keycode_filter.sv | 148 ++++++++++++++
 tb/tb_keycode_filter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/keycode_filter_if.sv
// Keycode filter bus: raw keycode in, debounced key, event pulses and status out.
// The filter is the slave; the keyboard side (or testbench) is the master.
interface keycode_filter_if;
    logic [7:0] keycode_in;
    logic [7:0] keycode_out;
    logic       press;
    logic       released;
    logic       rpt;
    logic [7:0] held_frames;
    logic [1:0] state;

    modport master (
        output keycode_in,
        input  keycode_out,
        input  press,
        input  released,
        input  rpt,
        input  held_frames,
        input  state
    );

    modport slave (
        input  keycode_in,
        output keycode_out,
        output press,
        output released,
        output rpt,
        output held_frames,
        output state
    );
endinterface

// File: rtl/keycode_filter.sv
// Debounces a raw per-frame USB keycode.
// Emits press/release/auto-repeat pulses; every output is registered.
module keycode_filter #(
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned REPEAT_DELAY  = 30,
    parameter int unsigned REPEAT_RATE   = 6
) (
    input  logic              frame_clk,
    input  logic              Reset,
    keycode_filter_if.slave   bus
);
    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StDebounce = 2'b01,
        StHeld     = 2'b10
    } state_e;

    localparam logic [3:0] Stable = 4'(STABLE_FRAMES);
    localparam logic [7:0] Delay  = 8'(REPEAT_DELAY);
    localparam logic [7:0] Rate   = 8'(REPEAT_RATE);

    state_e     state_q, state_d;
    logic [7:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rcnt_q, rcnt_d;
    logic [7:0] kout_q, kout_d;
    logic [7:0] held_q, held_d;
    logic       press_q, press_d;
    logic       rel_q, rel_d;
    logic       rpt_q, rpt_d;

    logic [7:0] key;
    logic [3:0] cnt_inc;

    assign key     = bus.keycode_in;
    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        kout_d  = kout_q;
        held_d  = held_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        rpt_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                kout_d = 8'h00;
                if (key != 8'h00) begin
                    cand_d = key;
                    cnt_d  = 4'd1;
                    if (STABLE_FRAMES == 1) begin
                        state_d = StHeld;
                        kout_d  = key;
                        press_d = 1'b1;
                        held_d  = 8'h00;
                        rcnt_d  = Delay;
                    end else begin
                        state_d = StDebounce;
                    end
                end
            end
            StDebounce: begin
                if (key == 8'h00) begin
                    state_d = StIdle;
                end else if (key == cand_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == Stable) begin
                        state_d = StHeld;
                        kout_d  = cand_q;
                        press_d = 1'b1;
                        held_d  = 8'h00;
                        rcnt_d  = Delay;
                    end
                end else begin
                    cand_d = key;
                    cnt_d  = 4'd1;
                end
            end
            StHeld: begin
                if (key == cand_q) begin
                    if (held_q != 8'hFF) begin
                        held_d = held_q + 8'd1;
                    end
                    // Repeat fires on the edge that sees the countdown at 1.
                    if (rcnt_q == 8'd1) begin
                        rpt_d  = 1'b1;
                        rcnt_d = Rate;
                    end else begin
                        rcnt_d = rcnt_q - 8'd1;
                    end
                end else begin
                    rel_d  = 1'b1;
                    kout_d = 8'h00;
                    held_d = 8'h00;
                    if (key == 8'h00) begin
                        state_d = StIdle;
                    end else begin
                        cand_d = key;
                        cnt_d  = 4'd1;
                        if (STABLE_FRAMES == 1) begin
                            kout_d  = key;
                            press_d = 1'b1;
                            rcnt_d  = Delay;
                        end else begin
                            state_d = StDebounce;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            cand_q  <= 8'h00;
            cnt_q   <= 4'd0;
            rcnt_q  <= 8'h00;
            kout_q  <= 8'h00;
            held_q  <= 8'h00;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            kout_q  <= kout_d;
            held_q  <= held_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rpt_q   <= rpt_d;
        end
    end

    assign bus.keycode_out = kout_q;
    assign bus.press       = press_q;
    assign bus.released    = rel_q;
    assign bus.rpt         = rpt_q;
    assign bus.held_frames = held_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_keycode_filter.sv
// Directed bench: default-parameter filter plus a STABLE_FRAMES=1 instance on one clock.
module tb_keycode_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    keycode_filter_if bus0();
    keycode_filter_if bus1();

    keycode_filter dut0 (
        .frame_clk (clk),
        .Reset     (rst),
        .bus       (bus0)
    );

    keycode_filter #(
        .STABLE_FRAMES (1)
    ) dut1 (
        .frame_clk (clk),
        .Reset     (rst),
        .bus       (bus1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One frame: drive both keys away from the edge, sample 1 time unit after it.
    task automatic step(input logic [7:0] k0, input logic [7:0] k1);
        @(negedge clk);
        bus0.keycode_in = k0;
        bus1.keycode_in = k1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus0.keycode_in = 8'h00;
        bus1.keycode_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(bus0.state), 32'h0);
        check("rst_kout", 32'(bus0.keycode_out), 32'h0);
        check("rst_held", 32'(bus0.held_frames), 32'h0);
        check("rst_pulses", {29'h0, bus0.press, bus0.released, bus0.rpt}, 32'h0);
        rst = 1'b0;

        // 1A held: press on edge 3, held_frames 2 on edge 5
        step(8'h1A, 8'h00);
        check("e1_state", 32'(bus0.state), 32'h1);
        check("e1_press", 32'(bus0.press), 32'h0);
        step(8'h1A, 8'h00);
        check("e2_kout", 32'(bus0.keycode_out), 32'h0);
        step(8'h1A, 8'h00);
        check("e3_press", 32'(bus0.press), 32'h1);
        check("e3_kout", 32'(bus0.keycode_out), 32'h1A);
        check("e3_state", 32'(bus0.state), 32'h2);
        check("e3_held", 32'(bus0.held_frames), 32'h0);
        step(8'h1A, 8'h00);
        check("e4_press", 32'(bus0.press), 32'h0);
        step(8'h1A, 8'h00);
        check("e5_held", 32'(bus0.held_frames), 32'h2);

        // Drop the key
        step(8'h00, 8'h00);
        check("rel_pulse", 32'(bus0.released), 32'h1);
        check("rel_kout", 32'(bus0.keycode_out), 32'h0);
        check("rel_state", 32'(bus0.state), 32'h0);
        step(8'h00, 8'h00);
        check("rel_once", 32'(bus0.released), 32'h0);

        // 04,04,07,07,07: candidate change restarts the count
        step(8'h04, 8'h00);
        step(8'h04, 8'h00);
        check("chg_e2_press", 32'(bus0.press), 32'h0);
        step(8'h07, 8'h00);
        check("chg_e3_press", 32'(bus0.press), 32'h0);
        step(8'h07, 8'h00);
        check("chg_e4_press", 32'(bus0.press), 32'h0);
        check("chg_e4_state", 32'(bus0.state), 32'h1);
        step(8'h07, 8'h00);
        check("chg_e5_press", 32'(bus0.press), 32'h1);
        check("chg_e5_kout", 32'(bus0.keycode_out), 32'h07);
        step(8'h00, 8'h00);

        // Key dropped during debounce: silent return to idle
        step(8'h05, 8'h00);
        step(8'h00, 8'h00);
        check("dbz_state", 32'(bus0.state), 32'h0);
        check("dbz_pulses", {30'h0, bus0.press, bus0.released}, 32'h0);

        // 16 held: repeats at held edges 30,36,42,...; held_frames saturates at 255
        step(8'h16, 8'h00);
        step(8'h16, 8'h00);
        step(8'h16, 8'h00);
        check("acc_press", 32'(bus0.press), 32'h1);
        check("acc_rpt", 32'(bus0.rpt), 32'h0);
        for (int k = 1; k <= 270; k++) begin
            step(8'h16, 8'h00);
            check($sformatf("rpt_k%0d", k), 32'(bus0.rpt),
                  32'((k >= 30) && ((k - 30) % 6 == 0)));
            check($sformatf("held_k%0d", k), 32'(bus0.held_frames),
                  (k > 255) ? 32'd255 : 32'(k));
            check($sformatf("nopress_k%0d", k), 32'(bus0.press), 32'h0);
        end

        // Switch to 07 and accept it, then reset mid-held
        step(8'h07, 8'h00);
        check("sw_rel", 32'(bus0.released), 32'h1);
        check("sw_state", 32'(bus0.state), 32'h1);
        step(8'h07, 8'h00);
        step(8'h07, 8'h00);
        check("sw_press", 32'(bus0.press), 32'h1);
        step(8'h07, 8'h00);
        check("sw_kout", 32'(bus0.keycode_out), 32'h07);
        #1 rst = 1'b1;
        #1;
        check("arst_kout", 32'(bus0.keycode_out), 32'h0);
        check("arst_state", 32'(bus0.state), 32'h0);
        check("arst_held", 32'(bus0.held_frames), 32'h0);
        @(posedge clk);
        #1;
        check("arst_norel", 32'(bus0.released), 32'h0);
        rst = 1'b0;
        step(8'h07, 8'h00);
        check("post_e1_press", 32'(bus0.press), 32'h0);
        step(8'h07, 8'h00);
        check("post_e2_press", 32'(bus0.press), 32'h0);
        step(8'h07, 8'h00);
        check("post_e3_press", 32'(bus0.press), 32'h1);
        check("post_e3_kout", 32'(bus0.keycode_out), 32'h07);

        // STABLE_FRAMES = 1 instance
        step(8'h00, 8'h04);
        check("sf1_press", 32'(bus1.press), 32'h1);
        check("sf1_kout", 32'(bus1.keycode_out), 32'h04);
        check("sf1_state", 32'(bus1.state), 32'h2);
        step(8'h00, 8'h07);
        check("sf1_sw_pr", {30'h0, bus1.press, bus1.released}, 32'h3);
        check("sf1_sw_kout", 32'(bus1.keycode_out), 32'h07);
        check("sf1_sw_held", 32'(bus1.held_frames), 32'h0);
        step(8'h00, 8'h07);
        check("sf1_hold_pr", {30'h0, bus1.press, bus1.released}, 32'h0);
        check("sf1_hold_held", 32'(bus1.held_frames), 32'h1);
        step(8'h00, 8'h00);
        check("sf1_rel", 32'(bus1.released), 32'h1);
        check("sf1_rel_kout", 32'(bus1.keycode_out), 32'h0);
        check("sf1_rel_state", 32'(bus1.state), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
